// File: rtl/seq_reg_param.sv
// Parametrised round-sequence register with a playback cursor.
// Stores up to DEPTH symbols of SYM_W bits, written either by a parallel
// load or by appending one symbol per round. A small read FSM walks the
// valid symbols so display/compare logic can replay the round sequence.
module seq_reg_param #(
    parameter  int SYM_W = 4,
    parameter  int DEPTH = 16,
    localparam int LEN_W = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   R,
    input  logic                   E,
    input  logic [DEPTH*SYM_W-1:0] data,
    input  logic [LEN_W-1:0]       len_in,
    input  logic                   app,
    input  logic [SYM_W-1:0]       sym_in,
    input  logic                   rd_start,
    input  logic                   rd_next,
    output logic [DEPTH*SYM_W-1:0] q,
    output logic [SYM_W-1:0]       q_head,
    output logic [LEN_W-1:0]       len,
    output logic                   full,
    output logic [SYM_W-1:0]       rd_sym,
    output logic                   rd_valid,
    output logic                   rd_last,
    output logic                   rd_done
);

    localparam int CUR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_DONE
    } state_t;

    logic [DEPTH*SYM_W-1:0] store_q, store_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [CUR_W-1:0]       cursor_q, cursor_d;
    state_t                 state_q, state_d;

    logic                   full_w;
    logic                   wr_accept;
    logic                   at_last;
    logic [SYM_W-1:0]       cur_sym;

    assign full_w    = (len_q == LEN_W'(DEPTH));
    assign wr_accept = E || (app && !full_w);
    assign at_last   = (LEN_W'(cursor_q) == (len_q - LEN_W'(1)));

    // Storage and length update: parallel load wins over append; append
    // while full leaves everything untouched.
    always_comb begin
        store_d = store_q;
        len_d   = len_q;
        if (E) begin
            store_d = data;
            len_d   = (len_in > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len_in;
        end else if (app && !full_w) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (len_q == LEN_W'(i)) begin
                    store_d[i*SYM_W +: SYM_W] = sym_in;
                end
            end
            len_d = len_q + LEN_W'(1);
        end
    end

    // Playback FSM next state; an accepted write forces IDLE and overrides
    // any read request in the same cycle.
    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        if (wr_accept) begin
            state_d  = ST_IDLE;
            cursor_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (rd_start) begin
                        cursor_d = '0;
                        state_d  = (len_q != '0) ? ST_PLAY : ST_DONE;
                    end
                end
                ST_PLAY: begin
                    if (rd_start) begin
                        cursor_d = '0;
                    end else if (rd_next) begin
                        if (at_last) begin
                            state_d = ST_DONE;
                        end else begin
                            cursor_d = cursor_q + CUR_W'(1);
                        end
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    cursor_d = '0;
                end
            endcase
        end
    end

    // Symbol under the cursor, selected from the registered store.
    always_comb begin
        cur_sym = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (cursor_q == CUR_W'(i)) begin
                cur_sym = store_q[i*SYM_W +: SYM_W];
            end
        end
    end

    // State registers with asynchronous reset that aborts writes and playback.
    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            store_q  <= '0;
            len_q    <= '0;
            cursor_q <= '0;
            state_q  <= ST_IDLE;
        end else begin
            store_q  <= store_d;
            len_q    <= len_d;
            cursor_q <= cursor_d;
            state_q  <= state_d;
        end
    end

    assign q        = store_q;
    assign q_head   = store_q[DEPTH*SYM_W-1 -: SYM_W];
    assign len      = len_q;
    assign full     = full_w;
    assign rd_valid = (state_q == ST_PLAY);
    assign rd_done  = (state_q == ST_DONE);
    assign rd_last  = rd_valid && at_last;
    assign rd_sym   = rd_valid ? cur_sym : '0;

endmodule

// File: tb/tb_seq_reg_param.sv
// Self-checking bench for seq_reg_param (SYM_W=4, DEPTH=16).
module tb_seq_reg_param;

    localparam int SYM_W = 4;
    localparam int DEPTH = 16;
    localparam int LEN_W = 5;

    logic                   clk;
    logic                   R;
    logic                   E;
    logic [DEPTH*SYM_W-1:0] data;
    logic [LEN_W-1:0]       len_in;
    logic                   app;
    logic [SYM_W-1:0]       sym_in;
    logic                   rd_start;
    logic                   rd_next;
    logic [DEPTH*SYM_W-1:0] q;
    logic [SYM_W-1:0]       q_head;
    logic [LEN_W-1:0]       len;
    logic                   full;
    logic [SYM_W-1:0]       rd_sym;
    logic                   rd_valid;
    logic                   rd_last;
    logic                   rd_done;

    int errors = 0;
    int checks = 0;

    seq_reg_param #(.SYM_W(SYM_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .R        (R),
        .E        (E),
        .data     (data),
        .len_in   (len_in),
        .app      (app),
        .sym_in   (sym_in),
        .rd_start (rd_start),
        .rd_next  (rd_next),
        .q        (q),
        .q_head   (q_head),
        .len      (len),
        .full     (full),
        .rd_sym   (rd_sym),
        .rd_valid (rd_valid),
        .rd_last  (rd_last),
        .rd_done  (rd_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        e;
        logic [63:0] d;
        logic [4:0]  li;
        logic        a;
        logic [3:0]  s;
        logic        rs;
        logic        rn;
        logic [4:0]  x_len;
        logic        x_full;
        logic        x_valid;
        logic        x_last;
        logic        x_done;
        logic [3:0]  x_sym;
        logic [63:0] x_q;
    } vec_t;

    vec_t tbl[13];

    // Reference model: array of symbols plus playback position and flags.
    logic [3:0] m_mem[DEPTH];
    int         m_n;
    int         m_cur;
    bit         m_play;
    bit         m_fin;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic e, input logic [63:0] d, input logic [4:0] li,
                         input logic a, input logic [3:0] s, input logic rs, input logic rn);
        E = e; data = d; len_in = li; app = a; sym_in = s; rd_start = rs; rd_next = rn;
    endtask

    task automatic idle_in();
        drive(1'b0, 64'h0, 5'd0, 1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    // One clock; outputs are then examined 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_in();
        @(posedge clk);
        #1 R = 1'b1;
        #2 R = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 4'h0;
        m_n = 0; m_cur = 0; m_play = 0; m_fin = 0;
    endtask

    task automatic model_step(input logic e, input logic [63:0] d, input logic [4:0] li,
                              input logic a, input logic [3:0] s, input logic rs, input logic rn);
        if (e) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = d[i*4 +: 4];
            m_n = (int'(li) > DEPTH) ? DEPTH : int'(li);
            m_cur = 0; m_play = 0; m_fin = 0;
        end else if (a && m_n < DEPTH) begin
            m_mem[m_n] = s;
            m_n++;
            m_cur = 0; m_play = 0; m_fin = 0;
        end else if (rs) begin
            m_cur = 0;
            m_play = (m_n > 0);
            m_fin  = (m_n == 0);
        end else if (rn && m_play) begin
            if (m_cur == m_n - 1) begin
                m_play = 0; m_fin = 1;
            end else begin
                m_cur++;
            end
        end
    endtask

    task automatic model_compare();
        logic [63:0] xq;
        for (int i = 0; i < DEPTH; i++) xq[i*4 +: 4] = m_mem[i];
        chk("rnd_q",      q,        xq);
        chk("rnd_q_head", q_head,   {60'h0, m_mem[DEPTH-1]});
        chk("rnd_len",    len,      64'(m_n));
        chk("rnd_full",   full,     64'(m_n == DEPTH));
        chk("rnd_valid",  rd_valid, 64'(m_play));
        chk("rnd_done",   rd_done,  64'(m_fin));
        chk("rnd_last",   rd_last,  64'(m_play && (m_cur == m_n - 1)));
        chk("rnd_sym",    rd_sym,   m_play ? {60'h0, m_mem[m_cur]} : 64'h0);
    endtask

    localparam logic [63:0] LD = 64'hF000_0000_0000_0ABC;

    initial begin
        logic [63:0] rq;
        logic        re, ra, rrs, rrn;
        logic [4:0]  rli;
        logic [3:0]  rs4;

        R = 1'b0;
        idle_in();

        //            e  data li  app sym rs rn | len full val last done sym q
        tbl[0]  = '{1'b0, 64'h0, 5'd0,  1'b1, 4'h3, 1'b0, 1'b0, 5'd1,  1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 64'h3};
        tbl[1]  = '{1'b0, 64'h0, 5'd0,  1'b1, 4'h1, 1'b0, 1'b0, 5'd2,  1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 64'h13};
        tbl[2]  = '{1'b0, 64'h0, 5'd0,  1'b1, 4'h2, 1'b0, 1'b0, 5'd3,  1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 64'h213};
        tbl[3]  = '{1'b0, 64'h0, 5'd0,  1'b0, 4'h0, 1'b1, 1'b0, 5'd3,  1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 64'h213};
        tbl[4]  = '{1'b0, 64'h0, 5'd0,  1'b0, 4'h0, 1'b0, 1'b1, 5'd3,  1'b0, 1'b1, 1'b0, 1'b0, 4'h1, 64'h213};
        tbl[5]  = '{1'b0, 64'h0, 5'd0,  1'b0, 4'h0, 1'b0, 1'b1, 5'd3,  1'b0, 1'b1, 1'b1, 1'b0, 4'h2, 64'h213};
        tbl[6]  = '{1'b0, 64'h0, 5'd0,  1'b0, 4'h0, 1'b0, 1'b1, 5'd3,  1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 64'h213};
        tbl[7]  = '{1'b0, 64'h0, 5'd0,  1'b0, 4'h0, 1'b0, 1'b1, 5'd3,  1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 64'h213};
        tbl[8]  = '{1'b1, LD,    5'd20, 1'b0, 4'h0, 1'b0, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, LD};
        tbl[9]  = '{1'b0, 64'h0, 5'd0,  1'b1, 4'h5, 1'b0, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, LD};
        tbl[10] = '{1'b0, 64'h0, 5'd0,  1'b0, 4'h0, 1'b1, 1'b0, 5'd16, 1'b1, 1'b1, 1'b0, 1'b0, 4'hC, LD};
        tbl[11] = '{1'b0, 64'h0, 5'd0,  1'b0, 4'h0, 1'b0, 1'b1, 5'd16, 1'b1, 1'b1, 1'b0, 1'b0, 4'hB, LD};
        tbl[12] = '{1'b0, 64'h0, 5'd0,  1'b1, 4'h5, 1'b0, 1'b0, 5'd16, 1'b1, 1'b1, 1'b0, 1'b0, 4'hB, LD};

        do_reset();
        chk("rst_q",     q,        64'h0);
        chk("rst_len",   len,      64'h0);
        chk("rst_full",  full,     64'h0);
        chk("rst_valid", rd_valid, 64'h0);
        chk("rst_done",  rd_done,  64'h0);
        chk("rst_sym",   rd_sym,   64'h0);

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].e, tbl[i].d, tbl[i].li, tbl[i].a, tbl[i].s, tbl[i].rs, tbl[i].rn);
            step();
            chk($sformatf("tbl%0d_len", i),   len,      64'(tbl[i].x_len));
            chk($sformatf("tbl%0d_full", i),  full,     64'(tbl[i].x_full));
            chk($sformatf("tbl%0d_valid", i), rd_valid, 64'(tbl[i].x_valid));
            chk($sformatf("tbl%0d_last", i),  rd_last,  64'(tbl[i].x_last));
            chk($sformatf("tbl%0d_done", i),  rd_done,  64'(tbl[i].x_done));
            chk($sformatf("tbl%0d_sym", i),   rd_sym,   64'(tbl[i].x_sym));
            chk($sformatf("tbl%0d_q", i),     q,        tbl[i].x_q);
            chk($sformatf("tbl%0d_head", i),  q_head,   64'(tbl[i].x_q[63:60]));
        end

        // Append together with rd_next mid-playback: write wins, FSM to IDLE.
        do_reset();
        drive(1'b1, 64'h4321, 5'd4, 1'b0, 4'h0, 1'b0, 1'b0); step();
        chk("mid_len0", len, 64'd4);
        drive(1'b0, 64'h0, 5'd0, 1'b0, 4'h0, 1'b1, 1'b0); step();
        drive(1'b0, 64'h0, 5'd0, 1'b0, 4'h0, 1'b0, 1'b1); step();
        chk("mid_sym1", rd_sym, 64'h2);
        drive(1'b0, 64'h0, 5'd0, 1'b1, 4'h7, 1'b0, 1'b1); step();
        chk("mid_len",   len,      64'd5);
        chk("mid_q",     q,        64'h7_4321);
        chk("mid_valid", rd_valid, 64'h0);
        chk("mid_done",  rd_done,  64'h0);
        chk("mid_sym",   rd_sym,   64'h0);
        drive(1'b0, 64'h0, 5'd0, 1'b0, 4'h0, 1'b1, 1'b0); step();
        chk("mid_restart_sym", rd_sym, 64'h1);

        // rd_start and rd_next together at cursor 2: restart wins.
        drive(1'b0, 64'h0, 5'd0, 1'b0, 4'h0, 1'b0, 1'b1); step();
        drive(1'b0, 64'h0, 5'd0, 1'b0, 4'h0, 1'b0, 1'b1); step();
        chk("both_pre_sym", rd_sym, 64'h3);
        drive(1'b0, 64'h0, 5'd0, 1'b0, 4'h0, 1'b1, 1'b1); step();
        chk("both_valid", rd_valid, 64'h1);
        chk("both_sym",   rd_sym,   64'h1);
        chk("both_last",  rd_last,  64'h0);

        // Asynchronous reset between edges while playing with len=5.
        idle_in();
        #2 R = 1'b1;
        #1;
        chk("arst_q",     q,        64'h0);
        chk("arst_len",   len,      64'h0);
        chk("arst_valid", rd_valid, 64'h0);
        #1 R = 1'b0;
        drive(1'b0, 64'h0, 5'd0, 1'b0, 4'h0, 1'b1, 1'b0); step();
        chk("empty_done",  rd_done,  64'h1);
        chk("empty_valid", rd_valid, 64'h0);
        chk("empty_sym",   rd_sym,   64'h0);
        chk("empty_last",  rd_last,  64'h0);

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 2000; c++) begin
            re  = ($urandom_range(0, 19) == 0);
            rq  = {$urandom(), $urandom()};
            rli = 5'($urandom_range(0, 20));
            ra  = ($urandom_range(0, 3) == 0);
            rs4 = 4'($urandom());
            rrs = ($urandom_range(0, 7) == 0);
            rrn = ($urandom_range(0, 1) == 0);
            drive(re, rq, rli, ra, rs4, rrs, rrn);
            step();
            model_step(re, rq, rli, ra, rs4, rrs, rrn);
            model_compare();
        end

        idle_in();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_reg_param.md
Name: seq_reg_param

Overview:
- Parametrised round-sequence register for the sequence game; successor to the fixed 64-bit sequence register.
- Holds up to DEPTH symbols of SYM_W bits each.
- Two write modes: whole-sequence parallel load, or append of one symbol per round.
- Has a playback cursor FSM that steps through the stored symbols so the display and compare logic can replay or check the round sequence.

Parameters:
- SYM_W, 4, bits per symbol (one symbol = one colour/button code).
- DEPTH, 16, maximum number of symbols stored (defaults give the 64-bit sequence).
- LEN_W is a localparam, not overridable: LEN_W = clog2(DEPTH)+1, so len can hold 0..DEPTH.

Ports:
- clk  in  1  clock, all state on rising edge.
- R  in  1  reset, asynchronous, active-high.
- E  in  1  parallel load enable.
- data  in  DEPTH*SYM_W  sequence for parallel load; symbol i = data[i*SYM_W +: SYM_W].
- len_in  in  LEN_W  number of valid symbols in data on a load.
- app  in  1  append sym_in at position len.
- sym_in  in  SYM_W  symbol to append.
- rd_start  in  1  (re)start playback at symbol 0.
- rd_next  in  1  advance playback cursor.
- q  out  DEPTH*SYM_W  full stored sequence, registered.
- q_head  out  SYM_W  top slot, q[DEPTH*SYM_W-1 -: SYM_W].
- len  out  LEN_W  number of valid symbols.
- full  out  1  len == DEPTH.
- rd_sym  out  SYM_W  symbol at cursor; 0 when rd_valid=0.
- rd_valid  out  1  FSM in PLAY.
- rd_last  out  1  rd_valid && cursor == len-1.
- rd_done  out  1  FSM in DONE.

Behaviour:
- Reset (R=1, async): store=0, len=0, cursor=0, FSM=IDLE. Hence q=0, q_head=0, full=0, rd_*=0. Reset asserted mid-playback or mid-write aborts everything immediately.
- Write priority: E over app.
- Parallel load (E=1): store <= data; len <= min(len_in, DEPTH). Symbols at index >= len keep the loaded values but are not played.
- Append (E=0, app=1, full=0): slot[len] <= sym_in; len <= len+1; other slots unchanged.
- Append while full: ignored; store and len unchanged.
- Accepted write (E, or app with full=0): FSM <= IDLE, cursor <= 0 on the same edge. This overrides rd_start and rd_next in that cycle.
- Latency: q, len and full reflect a write one cycle after the sampling edge.
- Read FSM, with no accepted write in the cycle:
  - IDLE: rd_start -> cursor<=0; next state PLAY if len>0, else DONE.
  - PLAY: rd_start -> cursor<=0, stay PLAY. Else rd_next with cursor==len-1 -> DONE. Else rd_next -> cursor<=cursor+1.
  - DONE: rd_start -> cursor<=0; next state PLAY if len>0, else DONE. rd_next ignored.
- rd_start has priority over rd_next in the same cycle.
- rd_sym is a combinational mux of registered store and cursor; valid in the same cycle rd_valid=1.
- The cursor never exceeds len-1 and never wraps. A stuck rd_next in DONE has no effect.
- Ignored write (append while full) does not disturb the FSM.
- Output flags (rd_valid, rd_last, rd_done, full) are decoded from state and len only, with no combinational path from inputs.

Test Plan (SYM_W=4, DEPTH=16):
- Reset then append 3, 1, 2 on consecutive cycles -> len=3, q[11:0]=12'h213, q_head=0, full=0. rd_start then 3x rd_next -> rd_sym 3,1,2. rd_last high on symbol 2; rd_done=1 after the third rd_next.
- Parallel load data=64'hF000_0000_0000_0ABC, len_in=20 -> len=16 (clamped), full=1, q_head=4'hF. A following app with sym_in=5 -> q and len unchanged.
- rd_start with len=0 -> next cycle rd_done=1, rd_valid=0, rd_sym=0.
- Mid-playback (cursor=1) assert app=1, sym_in=7 together with rd_next -> len increments, slot written, FSM IDLE, cursor=0, rd_valid=0.
- In PLAY at cursor=2, assert rd_start and rd_next together -> cursor=0, rd_valid stays 1.
- Assert R asynchronously between clock edges during PLAY with len=5 -> q, len, rd_valid immediately 0. After R release, rd_start -> rd_done=1 because len=0.
